// File: rtl/usb_ep_pkg.sv
// rtl/usb_ep_pkg.sv - shared types and constants for the USB bulk IN endpoint
// Purpose: FSM state encoding and the legal MAX_PKT payload sizes for full-speed bulk.
// Ports: none (package).
package usb_ep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_PUT      = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } ep_state_t;

  localparam int MAX_PKT_8  = 8;
  localparam int MAX_PKT_16 = 16;
  localparam int MAX_PKT_32 = 32;
  localparam int MAX_PKT_64 = 64;

endpackage

// File: rtl/usb_ep_byte_fifo.sv
// rtl/usb_ep_byte_fifo.sv - show-ahead byte FIFO for the bulk IN endpoint
// Purpose: power-of-two deep byte buffer; dout is the head byte straight from storage.
// Ports:
//   clk, reset (sync, active-low)
//   push, din  : write one byte (ignored when full)
//   pop        : drop the head byte (ignored when empty)
//   dout       : head byte, valid while !empty
//   level      : bytes buffered (0..FIFO_DEPTH)
//   full/empty : level == FIFO_DEPTH / level == 0
module usb_ep_byte_fifo #(
  parameter  int FIFO_DEPTH = 64,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_level == LW'(FIFO_DEPTH));
  assign empty = (r_level == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;

  // Pointers are exactly AW bits wide, so the +1 wraps modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/usb_bulk_in_ep.sv
// rtl/usb_bulk_in_ep.sv - bulk IN endpoint packetiser for one usb_fs_pe IN slot
// Purpose: buffers application bytes and sends them as packets of up to MAX_PKT bytes;
//   short packets leave on flush or after TIMEOUT_FRAMES SOFs. Optional macro
//   USB_BULK_IN_ZLP_EN appends a zero-length packet after a flushed full-size packet.
// Ports:
//   clk, reset (sync, active-low)
//   wr_valid/wr_ready/wr_data : application byte stream in
//   flush, stall, sof_valid   : flush pulse, halt level, SOF strobe
//   in_ep_req/grant           : PE arbiter handshake
//   in_ep_data_free/put/data  : byte transfer into the PE IN buffer
//   in_ep_data_done           : one-cycle end-of-packet pulse
//   in_ep_stall, in_ep_acked  : halt indication, host ACK
//   fifo_level                : bytes buffered
module usb_bulk_in_ep
  import usb_ep_pkg::*;
#(
  parameter  int FIFO_DEPTH     = 64,
  parameter  int MAX_PKT        = 32,
  parameter  int TIMEOUT_FRAMES = 2,
  localparam int LW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          stall,
  input  logic          sof_valid,
  output logic          in_ep_req,
  input  logic          in_ep_grant,
  input  logic          in_ep_data_free,
  output logic          in_ep_data_put,
  output logic [7:0]    in_ep_data,
  output logic          in_ep_data_done,
  output logic          in_ep_stall,
  input  logic          in_ep_acked,
  output logic [LW-1:0] fifo_level
);

  localparam int PW = $clog2(MAX_PKT) + 1;
  localparam int SW = $clog2(TIMEOUT_FRAMES + 1) + 1;

  ep_state_t     r_state;
  logic          r_req;
  logic          r_done;
  logic          r_flush_pend;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_pkt_len;
  logic [SW-1:0] r_sof_cnt;

  logic [LW-1:0] w_level;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_put;
  logic          w_timeout;
  logic          w_zlp_due;
  logic          w_level_nz;
  logic          w_full_pkt;
  logic          w_start;
  logic          w_last;
  logic [PW-1:0] w_pkt_len_next;

  usb_ep_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (wr_data),
    .pop   (w_put),
    .dout  (w_head),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_push     = wr_valid && !w_full;
  assign w_level_nz = (w_level != '0);
  assign w_full_pkt = (w_level >= LW'(MAX_PKT));
  assign w_timeout  = (TIMEOUT_FRAMES != 0) && (r_sof_cnt == SW'(TIMEOUT_FRAMES));

  // cnt < pkt_len already implies a byte is buffered; !empty is a belt-and-braces guard.
  assign w_put = (r_state == ST_PUT) && in_ep_grant && in_ep_data_free &&
                 (r_cnt < r_pkt_len) && !w_empty;

  assign w_start = !stall &&
                   (w_full_pkt || ((r_flush_pend || w_timeout) && w_level_nz) || w_zlp_due);

  assign w_pkt_len_next = w_zlp_due  ? '0 :
                          w_full_pkt ? PW'(MAX_PKT) : w_level[PW-1:0];

  // Leave PUT in the same cycle as the final put so done follows it directly.
  assign w_last = (r_pkt_len == '0) || (w_put && (r_cnt == r_pkt_len - PW'(1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_pkt_len <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (in_ep_grant) begin
            r_state   <= ST_PUT;
            r_pkt_len <= w_pkt_len_next;
            r_cnt     <= '0;
          end
        end
        ST_PUT: begin
          if (w_put) r_cnt <= r_cnt + PW'(1);
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_WAIT_ACK;
          r_req   <= 1'b0;
        end
        ST_WAIT_ACK: begin
          if (in_ep_acked) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Pending flush survives until the packet that drains the FIFO; an idle flush on an
  // empty FIFO with nothing owed simply evaporates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else if ((r_state == ST_DONE && !w_level_nz) ||
                 (r_state == ST_IDLE && !w_level_nz && !w_zlp_due)) begin
      r_flush_pend <= 1'b0;
    end
  end

  // SOF counter saturates at TIMEOUT_FRAMES; only counts while data waits in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sof_cnt <= '0;
    end else if (r_state != ST_IDLE || !w_level_nz) begin
      r_sof_cnt <= '0;
    end else if (sof_valid && r_sof_cnt != SW'(TIMEOUT_FRAMES)) begin
      r_sof_cnt <= r_sof_cnt + SW'(1);
    end
  end

`ifdef USB_BULK_IN_ZLP_EN
  // A flushed full-size packet that drains the FIFO is followed by a zero-length packet
  // so the host sees the transfer end.
  logic r_zlp_due;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_zlp_due <= 1'b0;
    end else if (r_state == ST_DONE) begin
      if (r_zlp_due) begin
        r_zlp_due <= 1'b0;
      end else if ((r_flush_pend || flush) && r_pkt_len == PW'(MAX_PKT) && !w_level_nz) begin
        r_zlp_due <= 1'b1;
      end
    end
  end
  assign w_zlp_due = r_zlp_due;
`else
  assign w_zlp_due = 1'b0;
`endif

  assign wr_ready        = !w_full;
  assign in_ep_req       = r_req;
  assign in_ep_data_done = r_done;
  assign in_ep_data_put  = w_put;
  assign in_ep_data      = (r_state == ST_PUT) ? w_head : 8'h00;
  assign in_ep_stall     = stall;
  assign fifo_level      = w_level;

endmodule
